// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, state encoding, ALU control and fault cause codes for the multi-cycle sequencer
package mc_pkg;
  localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
  localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd10
  } state_t;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
endpackage

// File: rtl/mc_timeout_counter.sv
// mc_timeout_counter: memory-wait cycle counter; ports clk, clr (sync clear), en (count), expired (count at TIMEOUT-1)
module mc_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  // TIMEOUT of zero never expires
  assign expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle Moore sequencer (fetch/decode/exec/mem/wb) with memory-ready handshake and fault reporting.
// Ports: i_clk, i_rst_n (sync active-low), i_OPCode, i_Zero, i_MemReady in; datapath strobes, o_Fault, o_FaultCause, o_State out.
// Optional MC_TIMEOUT_EN: memory waits longer than TIMEOUT cycles enter FAULT with cause 10.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_OPCode,
  input  logic       i_Zero,
  input  logic       i_MemReady,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_PCSrc,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_MemToReg,
  output logic [1:0] o_ALUOp,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic       o_RegWrite,
  output logic       o_Fault,
  output logic [1:0] o_FaultCause,
  output logic [3:0] o_State
);
  state_t     state;
  logic [1:0] cause;
  logic       timeout_hit;
  logic       zero_unused;
  // the datapath combines i_Zero with o_PCWriteCond itself
  assign zero_unused = i_Zero;
`ifdef MC_TIMEOUT_EN
  logic waiting;
  logic expired;
  assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // clearing whenever not counting leaves the counter at zero on entry to each wait state
  mc_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clk(i_clk),
    .clr(!i_rst_n || !waiting || i_MemReady),
    .en(waiting && !i_MemReady),
    .expired(expired)
  );
  assign timeout_hit = waiting && !i_MemReady && expired;
`else
  logic [31:0] cfg_unused;
  assign cfg_unused = TIMEOUT + CNT_W;
  assign timeout_hit = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= FETCH;
      cause <= CAUSE_NONE;
    end else begin
      case (state)
        FETCH:
          if (i_MemReady) state <= DECODE;
          else if (timeout_hit) begin
            state <= FAULT;
            cause <= CAUSE_TIMEOUT;
          end
        DECODE:
          case (i_OPCode)
            OP_R_TYPE:              state <= EXEC_R;
            OP_I_TYPE:              state <= EXEC_I;
            OP_I_L_TYPE, OP_S_TYPE: state <= ADDR;
            OP_B_TYPE:              state <= BRANCH;
            default: begin
              state <= FAULT;
              cause <= CAUSE_ILLEGAL;
            end
          endcase
        EXEC_R, EXEC_I: state <= WB_ALU;
        ADDR: state <= (i_OPCode == OP_I_L_TYPE) ? MEM_RD : MEM_WR;
        MEM_RD:
          if (i_MemReady) state <= WB_MEM;
          else if (timeout_hit) begin
            state <= FAULT;
            cause <= CAUSE_TIMEOUT;
          end
        MEM_WR:
          if (i_MemReady) state <= FETCH;
          else if (timeout_hit) begin
            state <= FAULT;
            cause <= CAUSE_TIMEOUT;
          end
        WB_ALU, WB_MEM, BRANCH: state <= FETCH;
        default: state <= FAULT;
      endcase
    end
  end
  always_comb begin
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_PCSrc       = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_IRWrite     = 1'b0;
    o_MemToReg    = 1'b0;
    o_ALUOp       = ALU_ADD;
    o_ALUSrcA     = 1'b0;
    o_ALUSrcB     = SRCB_RS2;
    o_RegWrite    = 1'b0;
    o_Fault       = 1'b0;
    o_FaultCause  = CAUSE_NONE;
    o_State       = 4'd0;
    if (i_rst_n) begin
      o_State      = state;
      o_FaultCause = cause;
      case (state)
        FETCH: begin
          o_MemRead = 1'b1;
          o_ALUSrcB = SRCB_FOUR;
          o_IRWrite = i_MemReady;
          o_PCWrite = i_MemReady;
        end
        DECODE: o_ALUSrcB = SRCB_IMM;
        EXEC_R: begin
          o_ALUSrcA = 1'b1;
          o_ALUOp   = ALU_RFN;
        end
        EXEC_I: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
          o_ALUOp   = ALU_IFN;
        end
        ADDR: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
        end
        MEM_RD: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
        end
        MEM_WR: begin
          o_MemWrite = 1'b1;
          o_IorD     = 1'b1;
        end
        WB_ALU: o_RegWrite = 1'b1;
        WB_MEM: begin
          o_RegWrite = 1'b1;
          o_MemToReg = 1'b1;
        end
        BRANCH: begin
          o_ALUSrcA     = 1'b1;
          o_ALUOp       = ALU_SUB;
          o_PCWriteCond = 1'b1;
          o_PCSrc       = 1'b1;
        end
        default: o_Fault = 1'b1;
      endcase
    end
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I core datapath. Replaces single-cycle main-control decoding with a Moore FSM.
- Walks each instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Waits on a memory-ready handshake at every memory access.
- Flags illegal opcodes and, optionally, memory timeouts.
- Supported opcodes: R-type, I-type ALU, load, store, branch.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for i_MemReady in a memory state. 0 disables the timeout. Used only with MC_TIMEOUT_EN.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_OPCode  in  7  instruction opcode field from the instruction register.
- i_Zero  in  1  ALU zero flag; branch taken when 1.
- i_MemReady  in  1  memory completes the current access this cycle.
- o_PCWrite  out  1  unconditional PC load.
- o_PCWriteCond  out  1  PC load qualified by i_Zero.
- o_PCSrc  out  1  0 = ALU result, 1 = ALUOut register.
- o_IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- o_MemRead  out  1  memory read request.
- o_MemWrite  out  1  memory write request.
- o_IRWrite  out  1  instruction register load.
- o_MemToReg  out  1  register writeback source: 0 = ALUOut, 1 = memory data register.
- o_ALUOp  out  2  00 add, 01 branch compare (sub), 10 R-type funct, 11 I-type funct.
- o_ALUSrcA  out  1  0 = PC, 1 = rs1.
- o_ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- o_RegWrite  out  1  register file write enable.
- o_Fault  out  1  sticky fault indicator.
- o_FaultCause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- o_State  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM. Outputs are combinational from state, except where an output is explicitly qualified by i_MemReady.
- Every output not listed for a state is 0.
- Reset: while i_rst_n=0, all control outputs are forced 0. On a clock edge with i_rst_n=0: state <= FETCH (encoding 0), counter <= 0, fault and cause cleared.
- Reset mid-operation: any state, including FAULT or a stalled memory wait, returns to FETCH on the next edge. Any in-flight access is abandoned.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=i_MemReady.
  - Stays in FETCH until i_MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target latched into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other opcode -> FAULT with cause 01
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: WB_ALU.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_RD if opcode is load, MEM_WR if store. Opcode is held stable by the instruction register.
- MEM_RD: MemRead=1, IorD=1. Waits for i_MemReady, then WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Waits for i_MemReady, then FETCH.
- WB_ALU: RegWrite=1, MemToReg=0. Next: FETCH.
- WB_MEM: RegWrite=1, MemToReg=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1. Next: FETCH.
- FAULT: all strobes 0, o_Fault=1. Absorbing state; only reset leaves it.
- Latency per instruction, in cycles, with zero memory wait:
  - R-type and I-type: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Each wait cycle adds 1.
- Request strobes (MemRead/MemWrite) stay asserted for the whole wait and drop in the cycle after i_MemReady=1.
- i_MemReady outside FETCH, MEM_RD and MEM_WR is ignored.

Optional Feature:
- Macro: MC_TIMEOUT_EN.
- Defined:
  - CNT_W-bit counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments each cycle in those states while i_MemReady=0.
  - If counter==TIMEOUT-1 and i_MemReady=0, the next state is FAULT with cause 10.
  - If i_MemReady=1 in that same cycle, the ready wins and the FSM proceeds normally.
  - TIMEOUT=0 means never time out.
- Undefined: no counter is built, waits are unbounded, and cause 10 is never produced.

Decomposition:
- Package mc_pkg holds:
  - opcode constants (OP_R_TYPE, OP_I_TYPE, OP_I_L_TYPE, OP_S_TYPE, OP_B_TYPE);
  - the 4-bit state encoding (FETCH=0 ... FAULT=10);
  - ALUOp and ALUSrcB codes;
  - fault cause codes.
- One sub-module, mc_timeout_counter (clear, enable, expired output), instantiated only under MC_TIMEOUT_EN.

Test Plan:
- Reset held low 3 cycles, then released, with i_MemReady=1:
  - during reset, all outputs are 0;
  - the first cycle after release, o_State=0 and o_MemRead=1.
- R-type, i_OPCode=0110011, i_MemReady=1 always:
  - state sequence FETCH, DECODE, EXEC_R, WB_ALU;
  - o_RegWrite=1 only in cycle 4;
  - o_ALUOp=10 in cycle 3.
- Load with 2-cycle memory wait in MEM_RD:
  - FETCH, DECODE, ADDR, MEM_RD ×3, WB_MEM (7 cycles);
  - o_MemRead=1 for all 3 MEM_RD cycles;
  - o_MemToReg=1 in WB_MEM.
- Branch, i_OPCode=1100011, i_Zero=1:
  - BRANCH state reached in cycle 3 with o_PCWriteCond=1, o_PCSrc=1, o_ALUOp=01;
  - next state is FETCH.
- i_OPCode=1111111:
  - after DECODE, o_Fault=1, o_FaultCause=01;
  - FSM stays in FAULT 10 cycles;
  - reset returns it to FETCH.
- MC_TIMEOUT_EN, TIMEOUT=4, i_MemReady=0 in FETCH:
  - FAULT on the 5th edge with cause 10;
  - a repeat run with i_MemReady=1 on the 4th FETCH cycle proceeds to DECODE.
